// File: rtl/m72_sample_player.sv
// m72_sample_player: sound CPU sample ports (ROM address latch, prefetching read-back, DAC) and stereo mixer
module m72_sample_player #(
  parameter int ROM_AW    = 18,
  parameter int DAC_SHIFT = 6
) (
  input  logic              CLK_32M,
  input  logic              RESET,
  input  logic [7:0]        snd_io_addr,
  input  logic [7:0]        snd_io_data,
  input  logic              snd_io_req,
  input  logic              snd_io_wr,
  input  logic              snd_io_rd,
  output logic [7:0]        sample_rd_data,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ack,
  input  logic [15:0]       ym_l,
  input  logic [15:0]       ym_r,
  output logic [7:0]        dac_out,
  output logic [15:0]       mix_l,
  output logic [15:0]       mix_r
);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, state_n;
  logic wr_q, rd_q, refetch, wr_ev, rd_ev, trig;
  logic [ROM_AW-1:0] sample_addr, sa_n;
  logic signed [17:0] d, s_l, s_r;
  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    return v > 18'sd32767 ? 16'h7FFF : v < -18'sd32768 ? 16'h8000 : v[15:0];
  endfunction
  assign rom_req = state == FETCH;
  always_comb begin
    wr_ev = snd_io_req & snd_io_wr & ~wr_q;
    rd_ev = snd_io_req & snd_io_rd & ~rd_q;
    sa_n = sample_addr;
    if (wr_ev && snd_io_addr == 8'h80) sa_n = {sample_addr[ROM_AW-1:13], snd_io_data, 5'd0};
    else if (wr_ev && snd_io_addr == 8'h81) sa_n = {snd_io_data[ROM_AW-14:0], sample_addr[12:0]};
    else if (rd_ev && snd_io_addr == 8'h84) sa_n = sample_addr + 1'b1;
    trig = (wr_ev && (snd_io_addr == 8'h80 || snd_io_addr == 8'h81)) || (rd_ev && snd_io_addr == 8'h84);
    state_n = state == IDLE ? (trig ? FETCH : IDLE) : ((rom_ack && !refetch && !trig) ? IDLE : FETCH);
    d = ($signed({10'd0, dac_out}) - 18'sd128) <<< DAC_SHIFT;
    s_l = $signed({{2{ym_l[15]}}, ym_l}) + d;
    s_r = $signed({{2{ym_r[15]}}, ym_r}) + d;
  end
  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      refetch        <= 1'b0;
      sample_addr    <= '0;
      rom_addr       <= '0;
      sample_rd_data <= 8'h00;
      dac_out        <= 8'h80;
      mix_l          <= 16'h0000;
      mix_r          <= 16'h0000;
    end else begin
      wr_q        <= snd_io_req & snd_io_wr;
      rd_q        <= snd_io_req & snd_io_rd;
      sample_addr <= sa_n;
      state       <= state_n;
      mix_l       <= sat16(s_l);
      mix_r       <= sat16(s_r);
      if (wr_ev && snd_io_addr == 8'h82) dac_out <= snd_io_data;
      if (state == IDLE && trig) rom_addr <= sa_n;
      // an ack that races a new trigger (or follows one) is stale: reissue instead of latching it
      if (state == FETCH) begin
        if (rom_ack) begin
          if (refetch || trig) rom_addr <= sa_n;
          else sample_rd_data <= rom_data;
          refetch <= 1'b0;
        end else if (trig) refetch <= 1'b1;
      end
    end
  end
endmodule
